// File: rtl/edge_arb_pkg.sv
// -----------------------------------------------------------------------------
// edge_arb_pkg
//   Shared types and helpers for the edge event arbiter.
//   - state_t : arbiter FSM states (idle / holding a presented event)
//   - pick_t  : result of a round-robin search {found, idx}
//   - rr_pick : round-robin search over a pending vector
// -----------------------------------------------------------------------------
package edge_arb_pkg;

   typedef enum logic {S_IDLE, S_HOLD} state_t;

   // The search helper works on a fixed maximum width so one function serves
   // every channel count up to MAX_CH.
   localparam int MAX_CH  = 32;
   localparam int MAX_CHW = 5;

   typedef struct packed {
      logic               found;
      logic [MAX_CHW-1:0] idx;
   } pick_t;

   // Search starts one past the last granted index and wraps at n_ch; the
   // first pending channel encountered wins.
   function automatic pick_t rr_pick(input logic [MAX_CH-1:0] pend,
                                     input int                last,
                                     input int                n_ch);
      pick_t r;
      int    c;
      r.found = 1'b0;
      r.idx   = '0;
      for (int i = 1; i <= MAX_CH; i++) begin
         if (i <= n_ch) begin
            c = (last + i) % n_ch;
            if (!r.found && pend[c]) begin
               r.found = 1'b1;
               r.idx   = c[MAX_CHW-1:0];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/dualedge_chan.sv
// -----------------------------------------------------------------------------
// dualedge_chan
//   One channel of the edge event arbiter: dual-edge detector plus a single
//   pending-event slot with polarity and a sticky overrun flag.
//   Ports:
//     i_clk, i_rst_n   clock, asynchronous active-low reset
//     i_lvl            synchronous level input for this channel
//     i_primed         edges are only recognised once the top has primed
//     i_grant          arbiter is taking this channel's pending event now
//     i_clr_overrun    clears the sticky overrun flag
//     o_pend           an event is waiting for the arbiter
//     o_pol            level after the most recent edge (1 = rising)
//     o_overrun        sticky: an edge arrived while an event was still pending
// -----------------------------------------------------------------------------
module dualedge_chan (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_lvl,
   input  logic i_primed,
   input  logic i_grant,
   input  logic i_clr_overrun,
   output logic o_pend,
   output logic o_pol,
   output logic o_overrun
);

   logic prev_lvl;
   logic edge_det;
   logic lost_edge;

   assign edge_det  = i_primed & (i_lvl ^ prev_lvl);
   // An edge landing on the grant cycle replaces the event being taken, so it
   // is not a loss.
   assign lost_edge = edge_det & o_pend & ~i_grant;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         prev_lvl  <= 1'b0;
         o_pend    <= 1'b0;
         o_pol     <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         prev_lvl <= i_lvl;
         if (edge_det) begin
            o_pend <= 1'b1;
            o_pol  <= i_lvl;
         end else if (i_grant) begin
            o_pend <= 1'b0;
         end
         // A new loss wins over a coincident clear.
         o_overrun <= lost_edge | (o_overrun & ~i_clr_overrun);
      end
   end

endmodule

// File: rtl/edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// edge_event_arbiter
//   Detects rise/fall events on N_CH synchronous level inputs, holds one
//   pending event per channel and presents them one at a time on a shared
//   valid/ready output, chosen round-robin.
//   Ports:
//     i_clk          system clock
//     i_rst_n        asynchronous active-low reset
//     i_lvl          level inputs, already synchronous to i_clk
//     i_ready        consumer accepts the presented event
//     i_clr_overrun  pulse: clears all overrun flags
//     o_valid        an event is presented on o_chan/o_rise
//     o_chan         channel index of the presented event
//     o_rise         1 = channel went high, 0 = channel went low
//     o_overrun      per-channel sticky lost-edge flags
// -----------------------------------------------------------------------------
module edge_event_arbiter
   import edge_arb_pkg::*;
#(
   parameter  int N_CH = 4,
   localparam int CHW  = $clog2(N_CH)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic [N_CH-1:0] i_lvl,
   input  logic            i_ready,
   input  logic            i_clr_overrun,
   output logic            o_valid,
   output logic [CHW-1:0]  o_chan,
   output logic            o_rise,
   output logic [N_CH-1:0] o_overrun
);

   logic            primed;
   logic [CHW-1:0]  rr_last;
   state_t          state;
   state_t          state_nxt;
   logic [N_CH-1:0] pend;
   logic [N_CH-1:0] pol;
   logic [N_CH-1:0] grant;
   logic            do_grant;
   logic [CHW-1:0]  sel_idx;
   pick_t           pick;
   logic            unused_pick_idx;

   for (genvar c = 0; c < N_CH; c++) begin : g_chan
      dualedge_chan u_chan (
         .i_clk         (i_clk),
         .i_rst_n       (i_rst_n),
         .i_lvl         (i_lvl[c]),
         .i_primed      (primed),
         .i_grant       (grant[c]),
         .i_clr_overrun (i_clr_overrun),
         .o_pend        (pend[c]),
         .o_pol         (pol[c]),
         .o_overrun     (o_overrun[c])
      );
   end

   assign pick            = rr_pick(MAX_CH'(pend), int'(rr_last), N_CH);
   assign sel_idx         = pick.idx[CHW-1:0];
   assign unused_pick_idx = ^pick.idx;

   // The first clock after reset only captures the input levels, so levels
   // that were already non-zero at release do not look like edges.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         primed <= 1'b0;
      end else begin
         primed <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // In S_HOLD an accepted event is replaced by the next pending one on the
   // same clock, giving one event per clock under sustained load.
   always_comb begin
      state_nxt = state;
      do_grant  = 1'b0;
      case (state)
         S_IDLE: begin
            if (pick.found) begin
               do_grant  = 1'b1;
               state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (i_ready) begin
               if (pick.found) begin
                  do_grant = 1'b1;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign grant = do_grant ? (N_CH'(1) << sel_idx) : '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_chan  <= '0;
         o_rise  <= 1'b0;
         rr_last <= CHW'(N_CH - 1);
      end else if (do_grant) begin
         o_chan  <= sel_idx;
         o_rise  <= pol[sel_idx];
         rr_last <= sel_idx;
      end
   end

   // Valid follows the state register directly so an asynchronous reset drops
   // it immediately.
   assign o_valid = (state == S_HOLD);

endmodule

// File: tb/tb_edge_event_arbiter.sv
module tb_edge_event_arbiter;

   typedef struct packed {
      logic [1:0] chan;
      logic       rise;
   } ev_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] lvl;
   logic       ready;
   logic       clr_ovr;
   logic       valid;
   logic [1:0] chan;
   logic       rise;
   logic [3:0] overrun;

   int   n_assert = 0;
   int   n_fail   = 0;
   bit   sb_en    = 1'b1;
   ev_t  sb[$];
   int   ev_log[$];

   edge_event_arbiter #(.N_CH(4)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_lvl         (lvl),
      .i_ready       (ready),
      .i_clr_overrun (clr_ovr),
      .o_valid       (valid),
      .o_chan        (chan),
      .o_rise        (rise),
      .o_overrun     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int c, input int r);
      ev_t e;
      e.chan = 2'(c);
      e.rise = 1'(r);
      sb.push_back(e);
   endtask

   // Accepted events (valid & ready at the next rising edge) are compared
   // against the scoreboard, or just logged when the scoreboard is off.
   always @(negedge clk) begin
      ev_t e;
      if (rst_n && valid && ready) begin
         if (sb_en) begin
            if (sb.size() == 0) begin
               chk("unexpected_event", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("sb_chan", int'(chan), int'(e.chan));
               chk("sb_rise", int'(rise), int'(e.rise));
            end
         end else begin
            ev_log.push_back(int'(chan));
         end
      end
   end

   initial begin
      int  guard;
      rst_n   = 1'b0;
      lvl     = 4'b1010;
      ready   = 1'b1;
      clr_ovr = 1'b0;

      // reset state, then release with non-zero levels: no events
      tick(2);
      chk("rst_valid", int'(valid), 0);
      chk("rst_chan", int'(chan), 0);
      chk("rst_rise", int'(rise), 0);
      chk("rst_overrun", int'(overrun), 0);
      rst_n = 1'b1;
      tick(5);
      chk("prime_overrun", int'(overrun), 0);
      chk("prime_valid", int'(valid), 0);

      // single rising edge on ch2, latency and one-cycle valid
      lvl = 4'b1110;
      push(2, 1);
      tick(1);
      chk("lat_k_valid", int'(valid), 0);
      tick(1);
      chk("lat_k1_valid", int'(valid), 1);
      chk("lat_k1_chan", int'(chan), 2);
      tick(1);
      chk("lat_k2_valid", int'(valid), 0);
      tick(2);

      // fresh reset so rr_last is N_CH-1, then all channels rise together
      rst_n = 1'b0;
      lvl   = 4'b0000;
      tick(1);
      rst_n = 1'b1;
      tick(3);
      lvl = 4'b1111;
      for (int c = 0; c < 4; c++) push(c, 1);
      tick(1);
      chk("all_rise_k_valid", int'(valid), 0);
      for (int c = 0; c < 4; c++) begin
         tick(1);
         chk("all_rise_valid", int'(valid), 1);
         chk("all_rise_chan", int'(chan), c);
      end
      tick(1);
      chk("all_rise_done", int'(valid), 0);
      lvl = 4'b0000;
      for (int c = 0; c < 4; c++) push(c, 0);
      tick(6);
      chk("all_fall_drained", sb.size(), 0);

      // back-pressure: outputs frozen, ch1 toggles twice -> overrun
      ready = 1'b0;
      lvl   = 4'b0010;
      push(1, 1);
      tick(2);
      chk("bp_valid", int'(valid), 1);
      chk("bp_chan", int'(chan), 1);
      lvl = 4'b0000;
      tick(1);
      lvl = 4'b0010;
      tick(1);
      chk("bp_overrun", int'(overrun), 4'b0010);
      for (int i = 0; i < 8; i++) begin
         tick(1);
         chk("bp_frozen", int'({valid, chan, rise}), 4'b1011);
      end
      push(1, 1);
      ready = 1'b1;
      tick(1);
      chk("bp_again_valid", int'(valid), 1);
      chk("bp_again_chan", int'(chan), 1);
      chk("bp_again_rise", int'(rise), 1);
      tick(1);
      chk("bp_end_valid", int'(valid), 0);
      chk("bp_overrun_sticky", int'(overrun), 4'b0010);
      clr_ovr = 1'b1;
      tick(1);
      clr_ovr = 1'b0;
      chk("clr_overrun", int'(overrun), 0);

      // ch0 toggles every clock, ch3 once: ch3 must not starve
      sb_en = 1'b0;
      ev_log.delete();
      lvl = 4'b1011;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         lvl[0] = ~lvl[0];
      end
      tick(4);
      guard = 0;
      while (valid && guard < 30) begin
         tick(1);
         guard++;
      end
      chk("starve_drain_timeout", int'(valid), 0);
      chk("starve_log_len", int'(ev_log.size() >= 2), 1);
      if (ev_log.size() >= 2)
         chk("starve_ch3_early", int'(ev_log[0] == 3 || ev_log[1] == 3), 1);
      chk("starve_ovr0", int'(overrun[0]), 1);
      chk("starve_ovr3", int'(overrun[3]), 0);
      clr_ovr = 1'b1;
      tick(1);
      clr_ovr = 1'b0;
      sb_en = 1'b1;

      // asynchronous reset while an event is presented
      ready = 1'b0;
      lvl   = lvl ^ 4'b0100;
      tick(2);
      chk("ares_pre_valid", int'(valid), 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("ares_valid_now", int'(valid), 0);
      chk("ares_chan_now", int'(chan), 0);
      lvl = 4'b1001;
      tick(2);
      rst_n = 1'b1;
      ready = 1'b1;
      tick(6);
      chk("ares_no_stale", int'(valid), 0);
      chk("ares_overrun", int'(overrun), 0);

      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
